// File: rtl/ghost_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ghost_pkg
// Brief   : Shared definitions for the ghost move scheduler: default ghost
//           count, scheduler state encoding, pointer width and period clamp.
// Rev     : 1.0 - initial release
// ============================================================================
package ghost_pkg;

  localparam int c_num_ghosts_def = 4;

  typedef enum logic [1:0] {
    ST_FROZEN   = 2'd0,
    ST_COUNT    = 2'd1,
    ST_DISPATCH = 2'd2
  } sched_state_t;

  // Width of a pointer that selects one of n ghosts (never zero).
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Move period after the score-dependent reduction, floored at min_p.
  // An offset at or beyond the base period also lands on the floor.
  function automatic logic [31:0] clamp_period(input logic [31:0] base_p,
                                               input logic [31:0] min_p,
                                               input logic [25:0] offset);
    logic [31:0] off_w;
    logic [31:0] diff;
    off_w = {6'd0, offset};
    diff  = base_p - off_w;
    if (off_w >= base_p)
      return min_p;
    else if (diff > min_p)
      return diff;
    else
      return min_p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ghost_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : ghost_rr_pick
// Brief   : Round-robin pick of the first pending ghost at or after the start
//           pointer, wrapping to bit 0. Produces a one-hot (or zero) grant.
// Rev     : 1.0 - initial release
// ============================================================================
module ghost_rr_pick
  import ghost_pkg::*;
#(
  parameter int NUM_GHOSTS = c_num_ghosts_def
) (
  input  logic [NUM_GHOSTS-1:0]        i_pending,
  input  logic [ptr_w(NUM_GHOSTS)-1:0] i_rr_ptr,
  output logic [NUM_GHOSTS-1:0]        o_grant
);

  logic [NUM_GHOSTS-1:0] w_thresh;
  logic [NUM_GHOSTS-1:0] w_upper;
  logic [NUM_GHOSTS-1:0] w_sel;

  // Bits at or above the pointer take priority; otherwise wrap to the
  // lowest pending bit. x & -x isolates the lowest set bit.
  assign w_thresh = {NUM_GHOSTS{1'b1}} << i_rr_ptr;
  assign w_upper  = i_pending & w_thresh;
  assign w_sel    = (w_upper != '0) ? w_upper : i_pending;
  assign o_grant  = w_sel & (-w_sel);

endmodule
`default_nettype wire

// File: rtl/ghost_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : ghost_move_scheduler
// Brief   : Period timer that, on each tick, queues the chase-enabled ghosts
//           and strobes them one per cycle in rotating order. Also drives the
//           face animation phase.
// Config  : define GHOST_SCHED_STATS_EN to build the tick/overrun counters;
//           otherwise both statistic outputs are tied to zero.
// Rev     : 1.0 - initial release
// ============================================================================
module ghost_move_scheduler
  import ghost_pkg::*;
#(
  parameter int NUM_GHOSTS  = c_num_ghosts_def,
  parameter int BASE_PERIOD = 4600000,
  parameter int MIN_PERIOD  = 100000,
  parameter int FACE_PERIOD = 40000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_run,
  input  logic [25:0]           i_speed_offset,
  input  logic [NUM_GHOSTS-1:0] i_zone_en,
  output logic [NUM_GHOSTS-1:0] o_move_stb,
  output logic                  o_face_phase,
  output logic                  o_busy,
  output logic [15:0]           o_tick_count,
  output logic [7:0]            o_overrun_count
);

  localparam int c_max_p = (BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD : MIN_PERIOD;
  localparam int c_tw    = $clog2(c_max_p + 1);
  localparam int c_fw    = (FACE_PERIOD > 1) ? $clog2(FACE_PERIOD) : 1;
  localparam int c_pw    = ptr_w(NUM_GHOSTS);

  sched_state_t          r_state, w_state_nxt;
  logic [c_tw-1:0]       r_timer, w_timer_nxt;
  logic [c_tw-1:0]       r_period, w_period_nxt, w_period_new;
  logic [NUM_GHOSTS-1:0] r_pending, w_pending_nxt;
  logic [c_pw-1:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic [c_fw-1:0]       r_face;
  logic [NUM_GHOSTS-1:0] w_grant;
  logic                  w_tick;

  ghost_rr_pick #(.NUM_GHOSTS(NUM_GHOSTS)) u_pick (
    .i_pending (r_pending),
    .i_rr_ptr  (r_rr_ptr),
    .o_grant   (w_grant)
  );

  assign w_period_new = c_tw'(clamp_period(32'(BASE_PERIOD), 32'(MIN_PERIOD), i_speed_offset));
  assign w_tick       = (r_state != ST_FROZEN) && (r_timer == r_period - c_tw'(1));

  // Strobes are suppressed as soon as run drops, so a freeze never emits a move.
  assign o_move_stb   = (r_state == ST_DISPATCH && i_run) ? w_grant : '0;
  assign o_busy       = (r_state == ST_DISPATCH);
  assign o_face_phase = (r_face >= c_fw'(FACE_PERIOD / 2));

  // State register plus timer, period latch, pending vector and start pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_FROZEN;
      r_timer   <= '0;
      r_period  <= '0;
      r_pending <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_period  <= w_period_nxt;
      r_pending <= w_pending_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
    end
  end

  // Next-state: freeze on run low, restart a period on run high, else time and dispatch.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_period_nxt  = r_period;
    w_pending_nxt = r_pending;
    w_rr_ptr_nxt  = r_rr_ptr;
    if (!i_run) begin
      w_state_nxt   = ST_FROZEN;
      w_timer_nxt   = '0;
      w_pending_nxt = '0;
    end else begin
      case (r_state)
        ST_FROZEN: begin
          w_state_nxt  = ST_COUNT;
          w_timer_nxt  = '0;
          w_period_nxt = w_period_new;
        end
        ST_COUNT, ST_DISPATCH: begin
          w_pending_nxt = r_pending & ~o_move_stb;
          if (w_tick) begin
            w_timer_nxt   = '0;
            w_period_nxt  = w_period_new;
            w_pending_nxt = w_pending_nxt | i_zone_en;
            w_state_nxt   = ST_DISPATCH;
            w_rr_ptr_nxt  = (r_rr_ptr == c_pw'(NUM_GHOSTS - 1)) ? '0 : r_rr_ptr + c_pw'(1);
          end else begin
            w_timer_nxt = r_timer + c_tw'(1);
            if (r_state == ST_DISPATCH && w_pending_nxt == '0)
              w_state_nxt = ST_COUNT;
          end
        end
        default: w_state_nxt = ST_FROZEN;
      endcase
    end
  end

  // Face animation counter advances only while running; holds when frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_face <= '0;
    else if (i_run && r_state != ST_FROZEN)
      r_face <= (r_face == c_fw'(FACE_PERIOD - 1)) ? '0 : r_face + c_fw'(1);
  end

`ifdef GHOST_SCHED_STATS_EN
  logic [15:0] r_tick_count;
  logic [7:0]  r_overrun_count;
  logic        w_tick_evt;

  assign w_tick_evt = i_run && w_tick;

  // Tick count wraps; an overrun is a tick arriving with moves still queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_count    <= '0;
      r_overrun_count <= '0;
    end else if (w_tick_evt) begin
      r_tick_count <= r_tick_count + 16'd1;
      if (r_pending != '0 && r_overrun_count != 8'hFF)
        r_overrun_count <= r_overrun_count + 8'd1;
    end
  end

  assign o_tick_count    = r_tick_count;
  assign o_overrun_count = r_overrun_count;
`else
  assign o_tick_count    = '0;
  assign o_overrun_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ghost_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_ghost_move_scheduler
// Brief   : Self-checking bench. A main instance (period 20, floor 8) and a
//           second instance whose period (4) forces overruns run side by side
//           against a behavioural model; directed checks cover latency,
//           clamping, zone patterns, freeze/restart, face phase and reset.
// Rev     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ghost_move_scheduler;

  logic        clk          = 1'b0;
  logic        reset        = 1'b1;
  logic        run          = 1'b0;
  logic [25:0] speed_offset = '0;
  logic [3:0]  zone_en      = '0;

  logic [3:0]  stb0, stb1;
  logic        face0, face1, busy0, busy1;
  logic [15:0] tc0, tc1;
  logic [7:0]  oc0, oc1;

  ghost_move_scheduler #(.NUM_GHOSTS(4), .BASE_PERIOD(20), .MIN_PERIOD(8), .FACE_PERIOD(40)) dut (
    .clk(clk), .reset(reset), .i_run(run), .i_speed_offset(speed_offset), .i_zone_en(zone_en),
    .o_move_stb(stb0), .o_face_phase(face0), .o_busy(busy0),
    .o_tick_count(tc0), .o_overrun_count(oc0));

  ghost_move_scheduler #(.NUM_GHOSTS(4), .BASE_PERIOD(4), .MIN_PERIOD(4), .FACE_PERIOD(40)) dut_ovr (
    .clk(clk), .reset(reset), .i_run(run), .i_speed_offset(speed_offset), .i_zone_en(zone_en),
    .o_move_stb(stb1), .o_face_phase(face1), .o_busy(busy1),
    .o_tick_count(tc1), .o_overrun_count(oc1));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state, one slot per instance.
  bit         m_act[2];
  bit         m_disp[2];
  int         m_timer[2];
  int         m_per[2];
  int         m_ptr[2];
  int         m_face[2];
  int         m_ticks[2];
  int         m_ovr[2];
  logic [3:0] m_pend[2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int mclamp(input int k, input int off);
    int b;
    int mn;
    int d;
    b  = (k == 0) ? 20 : 4;
    mn = (k == 0) ? 8 : 4;
    d  = b - off;
    return (d > mn) ? d : mn;
  endfunction

  function automatic logic [3:0] m_grant(input int k);
    int idx;
    if (!(m_disp[k] && run)) return 4'd0;
    for (int j = 0; j < 4; j++) begin
      idx = (m_ptr[k] + j) % 4;
      if (m_pend[k][idx]) return 4'(1 << idx);
    end
    return 4'd0;
  endfunction

  function automatic logic [15:0] exp_tc(input int k);
`ifdef GHOST_SCHED_STATS_EN
    return 16'(m_ticks[k]);
`else
    return 16'(k - k);
`endif
  endfunction

  function automatic logic [7:0] exp_oc(input int k);
`ifdef GHOST_SCHED_STATS_EN
    return 8'(m_ovr[k]);
`else
    return 8'(k - k);
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_disp[k] = 0; m_timer[k] = 0; m_per[k] = 0; m_ptr[k] = 0;
      m_face[k] = 0; m_ticks[k] = 0; m_ovr[k] = 0; m_pend[k] = 4'd0;
    end
  endtask

  task automatic model_step(input int k);
    logic [3:0] g;
    bit had;
    g = m_grant(k);
    if (!run) begin
      m_act[k] = 0; m_disp[k] = 0; m_timer[k] = 0; m_pend[k] = 4'd0;
    end else if (!m_act[k]) begin
      m_act[k] = 1; m_timer[k] = 0; m_per[k] = mclamp(k, int'(speed_offset));
    end else begin
      m_face[k] = (m_face[k] + 1) % 40;
      had = (m_pend[k] != 4'd0);
      m_pend[k] = m_pend[k] & ~g;
      if (m_timer[k] == m_per[k] - 1) begin
        m_timer[k] = 0;
        m_per[k]   = mclamp(k, int'(speed_offset));
        m_pend[k]  = m_pend[k] | zone_en;
        m_disp[k]  = 1;
        m_ptr[k]   = (m_ptr[k] + 1) % 4;
        m_ticks[k] = m_ticks[k] + 1;
        if (had && m_ovr[k] < 255) m_ovr[k] = m_ovr[k] + 1;
      end else begin
        m_timer[k] = m_timer[k] + 1;
        if (m_pend[k] == 4'd0) m_disp[k] = 0;
      end
    end
  endtask

  task automatic check_inst(input int k, input logic [3:0] s, input logic f, input logic b,
                            input logic [15:0] tc, input logic [7:0] oc);
    string p;
    p = (k == 0) ? "main" : "ovr";
    check_eq({p, "_stb"},    32'(s),  32'(m_grant(k)));
    check_eq({p, "_onehot"}, 32'($countones(s) <= 1), 32'd1);
    check_eq({p, "_busy"},   32'(b),  32'(m_disp[k]));
    check_eq({p, "_face"},   32'(f),  32'(m_face[k] >= 20));
    check_eq({p, "_ticks"},  32'(tc), 32'(exp_tc(k)));
    check_eq({p, "_ovr"},    32'(oc), 32'(exp_oc(k)));
  endtask

  // One clock: model advances at the active edge, outputs compared at the falling edge.
  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
    @(negedge clk);
    check_inst(0, stb0, face0, busy0, tc0, oc0);
    check_inst(1, stb1, face1, busy1, tc1, oc1);
  endtask

  task automatic window(input int n, output int strobes, output int rises,
                        output int busy_cyc, output int max_run);
    logic prev;
    int cur;
    prev = busy0; cur = 0;
    strobes = 0; rises = 0; busy_cyc = 0; max_run = 0;
    for (int i = 0; i < n; i++) begin
      step();
      strobes += $countones(stb0);
      if (busy0 && !prev) rises++;
      if (busy0) begin
        busy_cyc++; cur++;
        if (cur > max_run) max_run = cur;
      end else cur = 0;
      prev = busy0;
    end
  endtask

  logic [3:0] first_tbl [4];
  int s_cnt, r_cnt, b_cnt, m_run, lat, guard;

  initial begin
    first_tbl[0] = 4'b0010; first_tbl[1] = 4'b0100; first_tbl[2] = 4'b1000; first_tbl[3] = 4'b0001;
    model_reset();
    step(); step();
    check_eq("rst_stb",  32'(stb0),  32'd0);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_face", 32'(face0), 32'd0);
    check_eq("rst_tick", 32'(tc0),   32'd0);
    check_eq("rst_ovr",  32'(oc0),   32'd0);
    reset = 1'b0;
    step(); step();

    // First period after run: tick at 19, strobes 20..23, face phase flips at 20.
    zone_en = 4'b1111; speed_offset = '0; run = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      check_eq("first_stb",  32'(stb0),  (c >= 20 && c <= 23) ? 32'(first_tbl[c-20]) : 32'd0);
      check_eq("first_busy", 32'(busy0), 32'(c >= 20 && c <= 23));
      check_eq("face_phase", 32'(face0), 32'(c >= 20));
    end
    run = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("face_hold", 32'(face0), 32'd1);
    end

    // Clamped periods: 4 ticks of 4 strobes per 32 cycles.
    speed_offset = 26'd15; run = 1'b1;
    repeat (30) step();
    window(32, s_cnt, r_cnt, b_cnt, m_run);
    check_eq("clamp15_strobes", 32'(s_cnt), 32'd16);
    check_eq("clamp15_ticks",   32'(r_cnt), 32'd4);
    speed_offset = 26'd30;
    repeat (30) step();
    window(32, s_cnt, r_cnt, b_cnt, m_run);
    check_eq("clamp30_strobes", 32'(s_cnt), 32'd16);
    check_eq("clamp30_ticks",   32'(r_cnt), 32'd4);

    // Sparse and empty zone patterns.
    speed_offset = '0; zone_en = 4'b0101;
    repeat (60) step();
    window(40, s_cnt, r_cnt, b_cnt, m_run);
    check_eq("zone0101_strobes", 32'(s_cnt), 32'd4);
    zone_en = 4'b0000;
    repeat (60) step();
    window(40, s_cnt, r_cnt, b_cnt, m_run);
    check_eq("zone0000_strobes", 32'(s_cnt), 32'd0);
    check_eq("zone0000_busy",    32'(b_cnt), 32'd2);
    check_eq("zone0000_pulse",   32'(m_run), 32'd1);

    // Freeze on the second dispatch cycle, then restart.
    zone_en = 4'b1111;
    guard = 0;
    while (busy0 && guard < 50) begin step(); guard++; end
    while (!busy0 && guard < 50) begin step(); guard++; end
    check_eq("dispatch_seen", 32'(guard < 50), 32'd1);
    step();
    check_eq("second_dispatch", 32'(busy0), 32'd1);
    run = 1'b0;
    step();
    check_eq("drop_busy", 32'(busy0), 32'd0);
    s_cnt = $countones(stb0);
    for (int c = 0; c < 10; c++) begin step(); s_cnt += $countones(stb0); end
    check_eq("drop_strobes", 32'(s_cnt), 32'd0);
    run = 1'b1;
    lat = -1;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      step();
      if (busy0) lat = c;
    end
    check_eq("restart_latency", 32'(lat), 32'd20);

    // Asynchronous reset in the middle of a dispatch.
    check_eq("pre_rst_active", 32'(stb0 != 4'd0), 32'd1);
    #1 reset = 1'b1;
    model_reset();
    #1;
    check_eq("rst_mid_stb",  32'(stb0),  32'd0);
    check_eq("rst_mid_busy", 32'(busy0), 32'd0);
    step();
    check_eq("rst_mid_hold", 32'(stb0), 32'd0);
    reset = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      run = ($urandom_range(0, 19) != 0);
      if (i % 50 == 0) begin
        case ($urandom_range(0, 5))
          0: speed_offset = 26'd0;
          1: speed_offset = 26'd5;
          2: speed_offset = 26'd12;
          3: speed_offset = 26'($urandom_range(0, 25));
          4: speed_offset = 26'd30;
          default: speed_offset = 26'($urandom);
        endcase
      end
      zone_en = 4'($urandom);
      step();
    end

    // Sustained full load: the short-period instance overruns until saturation.
    run = 1'b1; zone_en = 4'b1111;
    repeat (1100) step();
`ifdef GHOST_SCHED_STATS_EN
    check_eq("ovr_saturated", 32'(oc1), 32'd255);
`else
    check_eq("ovr_tied_zero", 32'(oc1), 32'd0);
`endif
    check_eq("main_no_overrun", 32'(oc0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ghost_move_scheduler.md
GHOST_MOVE_SCHEDULER -- requirements
Module: ghost_move_scheduler

Interface
REQ-001 SHALL have parameter NUM_GHOSTS, default 4, number of ghost units scheduled.
REQ-002 SHALL have parameter BASE_PERIOD, default 4600000, move period in clk cycles at zero speed offset.
REQ-003 SHALL have parameter MIN_PERIOD, default 100000, lower clamp on move period; must be at least NUM_GHOSTS+1.
REQ-004 SHALL have parameter FACE_PERIOD, default 40000000, face-animation period in clk cycles.
REQ-005 SHALL have ports: clk in 1 system clock; reset in 1 asynchronous active-high reset.
REQ-006 SHALL have ports: run in 1 game active; speed_offset in 26 score-dependent period reduction; zone_en in NUM_GHOSTS per-ghost chase-permitted flags.
REQ-007 SHALL have ports: move_stb out NUM_GHOSTS one-hot one-cycle move strobe; face_phase out 1 face tile select; busy out 1 dispatch in progress.
REQ-008 SHALL have ports: tick_count out 16 period ticks issued; overrun_count out 8 overrun events.

Function
REQ-009 SHALL implement states FROZEN, COUNT and DISPATCH.
REQ-010 SHALL compute period = BASE_PERIOD - speed_offset when that exceeds MIN_PERIOD, else MIN_PERIOD, including speed_offset >= BASE_PERIOD.
REQ-011 SHALL latch period at every period start; a speed_offset change mid-period takes effect on the following period.
REQ-012 SHALL run a timer from 0 to period-1 while not FROZEN; tick = timer==period-1; on tick the timer returns to 0.
REQ-013 SHALL, on tick, OR zone_en into a pending vector, enter DISPATCH, and advance a rotating start pointer rr_ptr by 1 mod NUM_GHOSTS.
REQ-014 SHALL, each DISPATCH cycle, assert move_stb for the first pending ghost at or after rr_ptr (wrapping), then clear that pending bit.
REQ-015 SHALL give latency: tick at cycle T; k enabled ghosts strobe on consecutive cycles T+1..T+k.
REQ-016 SHALL return to COUNT in the cycle after the last pending bit clears; a tick with zone_en all-zero produces no strobes.
REQ-017 SHALL keep the timer running during DISPATCH.
REQ-018 SHALL, on a tick while pending is non-zero, OR in zone_en, count one overrun, and continue dispatching.
REQ-019 SHALL assert busy exactly while in DISPATCH; move_stb SHALL never have more than one bit set.
REQ-020 SHALL, on run deasserting in any state, go to FROZEN next cycle, clear pending, and zero the timer with no strobe.
REQ-021 SHALL, on run reasserting, start a fresh period at timer 0.
REQ-022 SHALL run a face counter 0..FACE_PERIOD-1 only while run=1; face_phase = 1 when count >= FACE_PERIOD/2; the counter holds in FROZEN.

Reset
REQ-023 SHALL, on reset, set state FROZEN, timer 0, pending 0, rr_ptr 0, face counter 0, move_stb 0, face_phase 0, busy 0, tick_count 0, overrun_count 0.
REQ-024 SHALL, with reset asserted mid-dispatch, drop move_stb immediately and issue no further strobes.

Configuration
REQ-025 SHALL, with GHOST_SCHED_STATS_EN defined, increment tick_count wrapping on each tick and increment overrun_count saturating at 255.
REQ-026 SHALL, without GHOST_SCHED_STATS_EN, tie tick_count and overrun_count to 0 and synthesize no counter logic.

Structure
REQ-027 SHALL take NUM_GHOSTS default, state encoding and the period clamp helper from shared package ghost_pkg.
REQ-028 SHALL place round-robin first-pending selection in sub-module ghost_rr_pick (inputs pending and rr_ptr, output one-hot grant).

Verification (BASE_PERIOD=20, MIN_PERIOD=8, FACE_PERIOD=40, NUM_GHOSTS=4)
REQ-029 SHALL verify: reset, run=1, speed_offset=0, zone_en=1111 -> first tick at cycle 19 after run, strobes 0010,0100,1000,0001 on cycles 20-23 (rr_ptr=1), busy high for 4 cycles.
REQ-030 SHALL verify: speed_offset=15 then 30 -> period clamps to 8 in both cases; ticks 8 cycles apart.
REQ-031 SHALL verify: zone_en=0101 -> exactly two strobes per period, one-hot; zone_en=0000 -> none, busy pulses at most one cycle.
REQ-032 SHALL verify: run dropped on the 2nd dispatch cycle -> no further strobes, busy 0 next cycle; run restored -> next tick 20 cycles later.
REQ-033 SHALL verify: face_phase 0 for cycles 0-19 and 1 for cycles 20-39 of run time, holding while run=0.
REQ-034 SHALL verify: stats build, period forced by MIN_PERIOD=4 with 4 ghosts enabled -> overrun_count increments; non-stats build -> both stat outputs read 0.
